alu_result_fifo: RTL and testbench
==================================

// Module: alu_result_fifo
// PURPOSE
//  Downstream stage of the 8-bit ALU. Captures each ALU result (y, carry-out, opcode tag) on a push strobe.
//  Buffers results in a small first-word-fall-through FIFO.
//  Presents them to the consumer (scoreboard/writeback) over a valid/ready handshake.
//  Decouples the ALU issue rate from consumer back-pressure; overflow is flagged, never silently hidden.
// PARAMETERS
//  DATA_W   8   width of ALU result y
//  OP_W     4   width of opcode tag
//  DEPTH    4   FIFO entries; power of 2, >= 2
// PORTS
//  clk          input   1                 single clock, all state on rising edge
//  reset        input   1                 asynchronous, active-low; 0 = in reset
//  wr_en_in     input   1                 push {co_in,y_in,op_in} this cycle
//  y_in         input   DATA_W            ALU y_out
//  co_in        input   1                 ALU co_out
//  op_in        input   OP_W              opcode that produced this result
//  rd_ready_in  input   1                 consumer accepts head entry
//  rd_valid_out output  1                 head entry valid (= !empty)
//  rd_y_out     output  DATA_W            head y
//  rd_co_out    output  1                 head carry-out
//  rd_op_out    output  OP_W              head opcode tag
//  count_out    output  $clog2(DEPTH)+1   entries held, 0..DEPTH
//  full_out     output  1                 count_out == DEPTH
//  empty_out    output  1                 count_out == 0
//  ovf_out      output  1                 sticky: a push was dropped
//  clr_ovf_in   input   1                 clears ovf_out
// BEHAVIOUR
//  Reset (reset=0, async assert, sync release):
//  - wr/rd pointers=0, count_out=0, empty_out=1, full_out=0, ovf_out=0, rd_valid_out=0.
//  - rd_y/co/op_out=0. Storage contents are don't-care.
//  - Reset mid-operation discards all entries immediately.
//  Pop:
//  - Occurs on an edge where rd_valid_out & rd_ready_in.
//  - rd_ready_in while empty is ignored.
//  Push:
//  - Occurs on an edge where wr_en_in & (!full_out | pop).
//  - Full with a simultaneous pop: the push is accepted and count is unchanged.
//  Data outputs:
//  - FWFT: rd_* outputs show mem[rd_ptr] combinationally from registered storage.
//  - When empty, rd_* outputs are forced to 0.
//  Latency:
//  - A push at edge N into an empty FIFO gives rd_valid_out=1 after edge N, with that data.
//  - There is no same-cycle write-through.
//  Simultaneous push+pop:
//  - When empty, only the push happens (pop impossible) and count becomes 1.
//  - Otherwise both happen and count is unchanged.
//  Pointers:
//  - $clog2(DEPTH) bits, increment modulo DEPTH (wrap DEPTH-1 -> 0).
//  - count_out is a separate counter: +1 on push only, -1 on pop only, unchanged on both or neither.
//  Overflow:
//  - A push when full_out & !pop is dropped: storage, pointers and count are unchanged.
//  - The same edge sets ovf_out=1.
//  - clr_ovf_in=1 clears ovf_out on the next edge; if set and clear coincide, set wins.
//  Flags: full_out/empty_out are derived from the registered count_out (glitch-free, no lookahead).
//  Ordering: strict FIFO; entry fields {co,y,op} always travel together.
// TESTING
//  1 Reset: hold reset=0 with random inputs -> all outputs 0 except empty_out=1; release -> still empty.
//  2 Single: push y=8'hA5,co=1,op=4'h3 -> next cycle rd_valid=1, rd_y=A5, rd_co=1, rd_op=3, count=1;
//    pop -> empty.
//  3 Fill/wrap: push 8'h01..8'h04 (full=1), pop 2, push 8'h05,8'h06 -> pops yield 03,04,05,06 in order.
//  4 Overflow: full, push 8'hFF with rd_ready=0 -> dropped, ovf_out=1, count=4;
//    clr_ovf_in -> ovf=0; clear+overflow same edge -> ovf stays 1.
//  5 Full push+pop: full, push 8'h77 and pop same edge -> head advances, count=4, no ovf;
//    8'h77 emerges last.
//  6 Mid-op reset: 3 entries held, pulse reset=0 for half a cycle -> immediate empty, count=0;
//    next push reads back correctly.

Source files
------------

// File: rtl/alu_result_fifo.sv
// Result buffer behind the 8-bit ALU: captures {co, y, op} on push and presents
// entries first-word-fall-through over valid/ready, with a sticky overflow flag.
module alu_result_fifo #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_in,
  input  logic [DATA_W-1:0]        y_in,
  input  logic                     co_in,
  input  logic [OP_W-1:0]          op_in,
  input  logic                     rd_ready_in,
  output logic                     rd_valid_out,
  output logic [DATA_W-1:0]        rd_y_out,
  output logic                     rd_co_out,
  output logic [OP_W-1:0]          rd_op_out,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     full_out,
  output logic                     empty_out,
  output logic                     ovf_out,
  input  logic                     clr_ovf_in
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + DATA_W + OP_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               ovf;
  logic               pop;
  logic               push;
  logic               drop;

  always_comb begin
    pop  = (count != '0) & rd_ready_in;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    push = wr_en_in & ((count != FULL_CNT) | pop);
    drop = wr_en_in & (count == FULL_CNT) & ~pop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)            ovf <= 1'b1;
      else if (clr_ovf_in) ovf <= 1'b0;
    end
  end

  // Storage needs no reset; empty masking below hides stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {co_in, y_in, op_in};
  end

  always_comb begin
    rd_valid_out = (count != '0);
    if (count == '0) begin
      rd_co_out = 1'b0;
      rd_y_out  = '0;
      rd_op_out = '0;
    end else begin
      {rd_co_out, rd_y_out, rd_op_out} = mem[rd_ptr];
    end
    count_out = count;
    full_out  = (count == FULL_CNT);
    empty_out = (count == '0);
    ovf_out   = ovf;
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: vector table for the main sequence plus
// hand-written reset and mid-operation reset sequences.
module tb_alu_result_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en_in;
  logic [7:0] y_in;
  logic       co_in;
  logic [3:0] op_in;
  logic       rd_ready_in;
  logic       rd_valid_out;
  logic [7:0] rd_y_out;
  logic       rd_co_out;
  logic [3:0] rd_op_out;
  logic [2:0] count_out;
  logic       full_out;
  logic       empty_out;
  logic       ovf_out;
  logic       clr_ovf_in;

  int unsigned checks = 0;
  int unsigned errors = 0;

  alu_result_fifo #(.DATA_W(8), .OP_W(4), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en_in     (wr_en_in),
    .y_in         (y_in),
    .co_in        (co_in),
    .op_in        (op_in),
    .rd_ready_in  (rd_ready_in),
    .rd_valid_out (rd_valid_out),
    .rd_y_out     (rd_y_out),
    .rd_co_out    (rd_co_out),
    .rd_op_out    (rd_op_out),
    .count_out    (count_out),
    .full_out     (full_out),
    .empty_out    (empty_out),
    .ovf_out      (ovf_out),
    .clr_ovf_in   (clr_ovf_in)
  );

  always #5 clk = ~clk;

  // Packed view: {valid, y, co, op, count, full, empty, ovf}
  typedef struct {
    logic        wr;
    logic [7:0]  y;
    logic        co;
    logic [3:0]  op;
    logic        rd;
    logic        clr;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [19:0] mk(input logic v, input logic [7:0] ey, input logic eco,
                                     input logic [3:0] eop, input logic [2:0] cnt, input logic ov);
    return {v, ey, eco, eop, cnt, (cnt == 3'd4), (cnt == 3'd0), ov};
  endfunction

  function automatic logic [19:0] actual();
    return {rd_valid_out, rd_y_out, rd_co_out, rd_op_out, count_out, full_out, empty_out, ovf_out};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got v=%0b y=%h co=%0b op=%h cnt=%0d full=%0b empty=%0b ovf=%0b, want v=%0b y=%h co=%0b op=%h cnt=%0d full=%0b empty=%0b ovf=%0b",
               name, act[19], act[18:11], act[10], act[9:6], act[5:3], act[2], act[1], act[0],
               exp[19], exp[18:11], exp[10], exp[9:6], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic add(input logic wr, input logic [7:0] y, input logic co, input logic [3:0] op,
                     input logic rd, input logic clr, input logic [19:0] exp);
    vec_t v;
    v.wr = wr; v.y = y; v.co = co; v.op = op; v.rd = rd; v.clr = clr; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic wr, input logic [7:0] y, input logic co, input logic [3:0] op,
                       input logic rd, input logic clr);
    wr_en_in = wr; y_in = y; co_in = co; op_in = op; rd_ready_in = rd; clr_ovf_in = clr;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 8'h00, 0, 4'h0, 0, 0);

    // Reset held with random inputs: outputs stay at reset values.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk); #1;
      check($sformatf("reset_hold_%0d", i), actual(), mk(0, 8'h00, 0, 4'h0, 3'd0, 0));
    end
    @(negedge clk);
    drive(0, 8'h00, 0, 4'h0, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_release", actual(), mk(0, 8'h00, 0, 4'h0, 3'd0, 0));

    // Single push/pop
    add(1, 8'hA5, 1, 4'h3, 0, 0, mk(1, 8'hA5, 1, 4'h3, 3'd1, 0));
    add(0, 8'h00, 0, 4'h0, 1, 0, mk(0, 8'h00, 0, 4'h0, 3'd0, 0));
    // Fill, partial drain, refill across pointer wrap
    add(1, 8'h01, 0, 4'h1, 0, 0, mk(1, 8'h01, 0, 4'h1, 3'd1, 0));
    add(1, 8'h02, 1, 4'h2, 0, 0, mk(1, 8'h01, 0, 4'h1, 3'd2, 0));
    add(1, 8'h03, 0, 4'h3, 0, 0, mk(1, 8'h01, 0, 4'h1, 3'd3, 0));
    add(1, 8'h04, 1, 4'h4, 0, 0, mk(1, 8'h01, 0, 4'h1, 3'd4, 0));
    add(0, 8'h00, 0, 4'h0, 1, 0, mk(1, 8'h02, 1, 4'h2, 3'd3, 0));
    add(0, 8'h00, 0, 4'h0, 1, 0, mk(1, 8'h03, 0, 4'h3, 3'd2, 0));
    add(1, 8'h05, 0, 4'h5, 0, 0, mk(1, 8'h03, 0, 4'h3, 3'd3, 0));
    add(1, 8'h06, 1, 4'h6, 0, 0, mk(1, 8'h03, 0, 4'h3, 3'd4, 0));
    // Overflow, clear, and clear colliding with overflow
    add(1, 8'hFF, 1, 4'hF, 0, 0, mk(1, 8'h03, 0, 4'h3, 3'd4, 1));
    add(0, 8'h00, 0, 4'h0, 0, 1, mk(1, 8'h03, 0, 4'h3, 3'd4, 0));
    add(1, 8'hFF, 1, 4'hF, 0, 1, mk(1, 8'h03, 0, 4'h3, 3'd4, 1));
    add(0, 8'h00, 0, 4'h0, 0, 1, mk(1, 8'h03, 0, 4'h3, 3'd4, 0));
    // Full with simultaneous push and pop
    add(1, 8'h77, 1, 4'h7, 1, 0, mk(1, 8'h04, 1, 4'h4, 3'd4, 0));
    add(0, 8'h00, 0, 4'h0, 1, 0, mk(1, 8'h05, 0, 4'h5, 3'd3, 0));
    add(0, 8'h00, 0, 4'h0, 1, 0, mk(1, 8'h06, 1, 4'h6, 3'd2, 0));
    add(0, 8'h00, 0, 4'h0, 1, 0, mk(1, 8'h77, 1, 4'h7, 3'd1, 0));
    add(0, 8'h00, 0, 4'h0, 1, 0, mk(0, 8'h00, 0, 4'h0, 3'd0, 0));
    // Ready while empty, push+pop while empty, push+pop with one entry
    add(0, 8'h00, 0, 4'h0, 1, 0, mk(0, 8'h00, 0, 4'h0, 3'd0, 0));
    add(1, 8'h5A, 0, 4'hF, 1, 0, mk(1, 8'h5A, 0, 4'hF, 3'd1, 0));
    add(1, 8'h3C, 1, 4'h2, 1, 0, mk(1, 8'h3C, 1, 4'h2, 3'd1, 0));
    add(0, 8'h00, 0, 4'h0, 1, 0, mk(0, 8'h00, 0, 4'h0, 3'd0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].wr, vecs[i].y, vecs[i].co, vecs[i].op, vecs[i].rd, vecs[i].clr);
      @(posedge clk); #1;
      check($sformatf("vec_%0d", i), actual(), vecs[i].exp);
    end

    // Mid-operation reset: load three entries, then a short asynchronous pulse.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 8'(8'h11 * (i + 1)), 1, 4'(i + 1), 0, 0);
      @(posedge clk); #1;
    end
    check("midop_loaded", actual(), mk(1, 8'h11, 1, 4'h1, 3'd3, 0));
    drive(0, 8'h00, 0, 4'h0, 0, 0);
    #1 reset = 1'b0;
    #1;
    check("midop_reset_async", actual(), mk(0, 8'h00, 0, 4'h0, 3'd0, 0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midop_after_release", actual(), mk(0, 8'h00, 0, 4'h0, 3'd0, 0));
    @(negedge clk);
    drive(1, 8'h99, 0, 4'h9, 0, 0);
    @(posedge clk); #1;
    check("midop_push_after", actual(), mk(1, 8'h99, 0, 4'h9, 3'd1, 0));
    @(negedge clk);
    drive(0, 8'h00, 0, 4'h0, 1, 0);
    @(posedge clk); #1;
    check("midop_pop_after", actual(), mk(0, 8'h00, 0, 4'h0, 3'd0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
